// File: rtl/serial_add_seq_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding.
package serial_add_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_seq_fa_cell.sv
// Combinational 1-bit full adder; the single arithmetic cell reused every cycle by serial_add_seq.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: one fa_cell stepped LSB first over WIDTH cycles.
// Optional macro SUB_EN adds the sub port and two's-complement subtraction (a-b).
module serial_add_seq
  import serial_add_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output state_t           state
);

  // Handshake: start is accepted only while busy==0 (IDLE or DONE) and ignored otherwise;
  // busy is high for exactly WIDTH cycles, then done pulses for one cycle with sum/cout valid.

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             load_carry;
  logic [WIDTH-1:0] load_b;

`ifdef SUB_EN
  assign load_carry = sub;
  assign load_b     = sub ? ~b : b;
`else
  assign load_carry = 1'b0;
  assign load_b     = b;
`endif

  fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            a_sh  <= a;
            b_sh  <= load_b;
            carry <= load_carry;
            cnt   <= '0;
            sum   <= '0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Result bits enter at the MSB so the word is LSB-aligned after WIDTH shifts.
          sum   <= {fa_sum, sum[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_cout;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= fa_cout;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
